// File: rtl/add_sub_pkg.sv
// Shared types and constants for the serial adder/subtractor.
// Contents: FSM state encoding and the operation select constants.
// Combinational-only declarations; no timing or backpressure implications.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_chunk.sv
// CHUNK-bit ripple-carry adder assembled from per-bit full-adder cells.
// Ports: a, b, cin in; sum, cout, msb_cin (carry into the top bit) out.
// Purely combinational, zero cycles; no handshake.
module fa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // The carry chain lives inside a single process so the ripple is
  // evaluated in bit order rather than as a feedback loop on one vector.
  logic [CHUNK:0] c;

  always_comb begin
    c      = '0;
    sum    = '0;
    c[0]   = cin;
    for (int i = 0; i < CHUNK; i++) begin
      {c[i+1], sum[i]} = full_add(a[i], b[i], c[i]);
    end
  end

  assign cout    = c[CHUNK];
  assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/add_sub_serial.sv
// Multi-cycle two's-complement add/sub, CHUNK bits per clock with a registered carry.
// Latency: result valid N=WIDTH/CHUNK cycles after acceptance; N+2 cycles per op.
// Backpressure: single request in flight; result held in DONE until i_ready.
// Ports: i_clk, i_rst (sync, active-high), i_valid/o_ready request side with
// i_a, i_b, i_sub; o_valid/i_ready result side with o_sum, o_cout, and o_ovf
// when ADD_SUB_SERIAL_OVF_EN is defined. WIDTH must be a multiple of CHUNK.
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
`ifdef ADD_SUB_SERIAL_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q;

  logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
  logic             cout_sl, msb_cin_sl;
  logic             accept, xfer, last;

  // Handshake outputs decode the state register only.
  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign accept  = i_valid & o_ready;
  assign xfer    = o_valid & i_ready;
  assign last    = (k_q == K_LAST);

  // Select slice k; B is inverted for subtract, the +1 comes from the
  // carry register being preset to 1 at acceptance.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK] ^ {CHUNK{sub_q == OP_SUB}};
      end
    end
  end

  fa_chunk #(.CHUNK(CHUNK)) u_fa_chunk (
    .a       (a_sl),
    .b       (b_sl),
    .cin     (carry_q),
    .sum     (sum_sl),
    .cout    (cout_sl),
    .msb_cin (msb_cin_sl)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last)   state_d = DONE;
      DONE:    if (xfer)   state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Datapath. o_sum is only written slice-by-slice in CALC, so the previous
  // result stays visible through DONE and IDLE until the next first slice.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= OP_ADD;
      o_sum   <= '0;
      o_cout  <= 1'b0;
`ifdef ADD_SUB_SERIAL_OVF_EN
      o_ovf   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= i_a;
            b_q     <= i_b;
            sub_q   <= i_sub;
            k_q     <= '0;
            carry_q <= (i_sub == OP_SUB);
          end
        end
        CALC: begin
          for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) o_sum[i*CHUNK +: CHUNK] <= sum_sl;
          end
          carry_q <= cout_sl;
          k_q     <= k_q + KW'(1);
          if (last) begin
            o_cout <= cout_sl;
`ifdef ADD_SUB_SERIAL_OVF_EN
            // Signed overflow: carry into the sign bit differs from carry out.
            o_ovf  <= msb_cin_sl ^ cout_sl;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // The MSB carry-in tap must be consistent with the chunk carry-out.
  a_msb_carry : assert property (@(posedge i_clk) disable iff (i_rst)
    (state_q == CALC) |->
      (cout_sl == ((a_sl[CHUNK-1] & b_sl[CHUNK-1]) |
                   (msb_cin_sl & (a_sl[CHUNK-1] ^ b_sl[CHUNK-1])))));

endmodule

// File: tb/tb_add_sub_serial.sv
module tb_add_sub_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // 16-bit, 4-bit chunk instance
  logic        in_valid = 1'b0, rdy, vld, out_ready = 1'b1, in_sub = 1'b0, cout;
  logic [15:0] in_a = '0, in_b = '0, sum;
  logic        ovf;
  // 8-bit, single chunk instance
  logic        in8_valid = 1'b0, rdy8, vld8, out8_ready = 1'b1, in8_sub = 1'b0, cout8;
  logic [7:0]  in8_a = '0, in8_b = '0, sum8;
  logic        ovf8;

  int vec = 0;
  int miss = 0;

  add_sub_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy),
    .i_a(in_a), .i_b(in_b), .i_sub(in_sub), .o_valid(vld), .i_ready(out_ready),
    .o_sum(sum), .o_cout(cout)
`ifdef ADD_SUB_SERIAL_OVF_EN
    , .o_ovf(ovf)
`endif
  );

  add_sub_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(in8_valid), .o_ready(rdy8),
    .i_a(in8_a), .i_b(in8_b), .i_sub(in8_sub), .o_valid(vld8), .i_ready(out8_ready),
    .o_sum(sum8), .o_cout(cout8)
`ifdef ADD_SUB_SERIAL_OVF_EN
    , .o_ovf(ovf8)
`endif
  );

`ifndef ADD_SUB_SERIAL_OVF_EN
  assign ovf  = 1'b0;
  assign ovf8 = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the 16-bit DUT and wait (bounded) for its result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output int lat, output logic [15:0] s, output logic c, output logic v);
    int guard = 0;
    while (!rdy && guard < 50) begin step(); guard++; end
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!vld && lat < 20) begin step(); lat++; end
    s = sum; c = cout; v = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    vec++; if (rdy !== 1'b1)   begin miss++; $display("FAIL reset_ready: got %b want 1", rdy); end
    vec++; if (vld !== 1'b0)   begin miss++; $display("FAIL reset_valid: got %b want 0", vld); end
    vec++; if (sum !== 16'h0)  begin miss++; $display("FAIL reset_sum: got %h want 0000", sum); end
    vec++; if (cout !== 1'b0)  begin miss++; $display("FAIL reset_cout: got %b want 0", cout); end
`ifdef ADD_SUB_SERIAL_OVF_EN
    vec++; if (ovf !== 1'b0)   begin miss++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    vec++; if (rdy8 !== 1'b1 || vld8 !== 1'b0 || sum8 !== 8'h0)
      begin miss++; $display("FAIL reset_dut8: got rdy=%b vld=%b sum=%h want 1 0 00", rdy8, vld8, sum8); end
  endtask

  // Operand table: a, b, sub, expected sum, cout, ovf
  task automatic test_arith();
    logic [15:0] ta [6] = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h0005, 16'h8000, 16'h0000};
    logic [15:0] tb [6] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000};
    logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] es [6] = '{16'h2233, 16'h8000, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h0000};
    logic        ec [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        eo [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat; logic [15:0] s; logic c, v;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], ts[i], lat, s, c, v);
      vec++; if (lat !== 4) begin miss++; $display("FAIL arith%0d_latency: got %0d want 4", i, lat); end
      vec++; if (s !== es[i]) begin miss++; $display("FAIL arith%0d_sum: got %h want %h", i, s, es[i]); end
      vec++; if (c !== ec[i]) begin miss++; $display("FAIL arith%0d_cout: got %b want %b", i, c, ec[i]); end
`ifdef ADD_SUB_SERIAL_OVF_EN
      vec++; if (v !== eo[i]) begin miss++; $display("FAIL arith%0d_ovf: got %b want %b", i, v, eo[i]); end
`endif
      vec++; if (rdy !== 1'b0) begin miss++; $display("FAIL arith%0d_ready_in_done: got %b want 0", i, rdy); end
      step();
      vec++; if (vld !== 1'b0 || rdy !== 1'b1)
        begin miss++; $display("FAIL arith%0d_after_xfer: got vld=%b rdy=%b want 0 1", i, vld, rdy); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] s; logic c, v;
    out_ready = 1'b0;
    run_op(16'hAAAA, 16'h1111, 1'b0, lat, s, c, v);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_sub = 1'b1;
      end
      vec++; if (vld !== 1'b1 || rdy !== 1'b0)
        begin miss++; $display("FAIL stall%0d_handshake: got vld=%b rdy=%b want 1 0", i, vld, rdy); end
      vec++; if (sum !== 16'hBBBB || cout !== 1'b0)
        begin miss++; $display("FAIL stall%0d_hold: got sum=%h cout=%b want bbbb 0", i, sum, cout); end
      if (i < 3) step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    vec++; if (vld !== 1'b0 || rdy !== 1'b1)
      begin miss++; $display("FAIL stall_release: got vld=%b rdy=%b want 0 1", vld, rdy); end
    for (int i = 0; i < 6; i++) step();
    vec++; if (vld !== 1'b0 || sum !== 16'hBBBB)
      begin miss++; $display("FAIL stall_no_capture: got vld=%b sum=%h want 0 bbbb", vld, sum); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] s; logic c, v;
    in_a = 16'h1234; in_b = 16'h0FFF; in_sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();  // now at slice k=2
    rst = 1'b1;
    step();
    rst = 1'b0;
    vec++; if (rdy !== 1'b1 || vld !== 1'b0)
      begin miss++; $display("FAIL midrst_handshake: got rdy=%b vld=%b want 1 0", rdy, vld); end
    vec++; if (sum !== 16'h0 || cout !== 1'b0)
      begin miss++; $display("FAIL midrst_outputs: got sum=%h cout=%b want 0000 0", sum, cout); end
    run_op(16'h0001, 16'h0001, 1'b0, lat, s, c, v);
    vec++; if (s !== 16'h0002 || lat !== 4)
      begin miss++; $display("FAIL midrst_next_op: got sum=%h lat=%0d want 0002 4", s, lat); end
    step();
  endtask

  task automatic test_reset_with_valid();
    rst = 1'b1;
    in_valid = 1'b1; in_a = 16'h0101; in_b = 16'h0202; in_sub = 1'b0;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    vec++; if (rdy !== 1'b1 || vld !== 1'b0)
      begin miss++; $display("FAIL rstvalid_state: got rdy=%b vld=%b want 1 0", rdy, vld); end
    for (int i = 0; i < 6; i++) step();
    vec++; if (vld !== 1'b0 || sum !== 16'h0)
      begin miss++; $display("FAIL rstvalid_dropped: got vld=%b sum=%h want 0 0000", vld, sum); end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int both = 0;
    in_a = 16'h0100; in_b = 16'h0023; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (rdy) acc++;
      if (rdy && vld) both++;
      step();
    end
    in_valid = 1'b0;
    vec++; if (acc !== 5) begin miss++; $display("FAIL b2b_accepts: got %0d want 5", acc); end
    vec++; if (both !== 0) begin miss++; $display("FAIL b2b_ready_and_valid: got %0d want 0", both); end
    vec++; if (sum !== 16'h0123 || rdy !== 1'b1)
      begin miss++; $display("FAIL b2b_result: got sum=%h rdy=%b want 0123 1", sum, rdy); end
  endtask

  task automatic test_single_chunk();
    in8_a = 8'hF0; in8_b = 8'h20; in8_sub = 1'b0; in8_valid = 1'b1;
    step();
    in8_valid = 1'b0;
    step();
    vec++; if (vld8 !== 1'b1) begin miss++; $display("FAIL n1_latency: got vld=%b want 1", vld8); end
    vec++; if (sum8 !== 8'h10 || cout8 !== 1'b1)
      begin miss++; $display("FAIL n1_add: got sum=%h cout=%b want 10 1", sum8, cout8); end
`ifdef ADD_SUB_SERIAL_OVF_EN
    vec++; if (ovf8 !== 1'b0) begin miss++; $display("FAIL n1_add_ovf: got %b want 0", ovf8); end
`endif
    step();
    vec++; if (vld8 !== 1'b0 || rdy8 !== 1'b1)
      begin miss++; $display("FAIL n1_xfer: got vld=%b rdy=%b want 0 1", vld8, rdy8); end
    in8_a = 8'h20; in8_b = 8'hF0; in8_sub = 1'b1; in8_valid = 1'b1;
    step();
    in8_valid = 1'b0;
    step();
    vec++; if (vld8 !== 1'b1 || sum8 !== 8'h30 || cout8 !== 1'b0)
      begin miss++; $display("FAIL n1_sub: got vld=%b sum=%h cout=%b want 1 30 0", vld8, sum8, cout8); end
    step();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_reset_with_valid();
    test_back_to_back();
    test_single_chunk();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Parametrised, multi-cycle two's-complement adder/subtractor that processes a WIDTH-bit operand pair in CHUNK-bit slices, one slice per clock, carrying between slices in a register. It trades latency for area against the flat ripple adders in the arithmetic library. A valid/ready handshake on both sides lets it sit between a register-file read port and a writeback stage that may stall.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits processed per cycle. WIDTH % CHUNK == 0 and CHUNK >= 1; N = WIDTH/CHUNK.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_sub  input  1  0 = A+B, 1 = A−B.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_sum  output  WIDTH  result, modulo 2^WIDTH.
- o_cout  output  1  carry out of the MSB. For subtract, 1 = no borrow (A ≥ B unsigned).
- o_ovf  output  1  signed overflow. Present only with ADD_SUB_SERIAL_OVF_EN.

## Operation
- FSM states:
  - IDLE: o_ready=1.
  - CALC: slice index k = 0..N−1.
  - DONE: o_valid=1.
- IDLE→CALC on i_valid && o_ready. At that edge:
  - Latch i_a, i_b and i_sub.
  - Set k=0.
  - Set carry register to i_sub.
- Operand B handling: each slice uses B XOR {CHUNK{sub}}. The initial carry of 1 completes two's-complement negation.
- CALC, each cycle:
  - Slice k of A, (possibly inverted) B and the carry register feed the chunk adder.
  - The CHUNK-bit sum is written into o_sum[k*CHUNK +: CHUNK].
  - The slice carry-out is written to the carry register.
  - k increments.
- CALC→DONE on the edge that processes slice N−1. At that edge:
  - o_cout takes the final carry.
  - o_ovf takes the carry-in XOR carry-out of bit WIDTH−1.
- DONE→IDLE on o_valid && i_ready.
- Input acceptance: i_valid is ignored whenever o_ready=0. There is no request buffering and no overlap of requests.
- Output hold: o_sum, o_cout and o_ovf are held stable from DONE entry until the next request's first CALC edge. Only o_valid qualifies them.
- Reset: i_rst overrides everything. Any in-flight operation is discarded and the FSM goes to IDLE.

## Timing
- Reset values:
  - o_ready=1
  - o_valid=0
  - o_sum=0
  - o_cout=0
  - o_ovf=0
  - internal state: IDLE, k=0, carry=0.
- Latency: with acceptance at edge E0, o_valid rises after edge E0+N and remains high until the transfer edge.
- Throughput: with i_ready held high, one operation per N+2 cycles (accept, N CALC cycles, DONE transfer cycle). o_ready returns to 1 the cycle after the transfer.
- Handshake signals:
  - o_ready and o_valid are registered state decodes, with no combinational path from i_valid or i_ready.
  - o_ready and o_valid are never both 1.
- CHUNK = WIDTH (N=1): CALC lasts exactly one cycle; o_valid appears one cycle after acceptance.
- Reset asserted in the same cycle as i_valid: the request is dropped.

## Configuration
- ADD_SUB_SERIAL_OVF_EN defined:
  - o_ovf port exists.
  - Signed overflow is computed and registered as above.
- ADD_SUB_SERIAL_OVF_EN undefined:
  - o_ovf port and its register are absent.
  - All other behaviour is identical.

## Structure
- Package add_sub_pkg holds:
  - state enum typedef (IDLE, CALC, DONE).
  - op constants OP_ADD=1'b0 and OP_SUB=1'b1.
- Sub-module fa_chunk is a purely combinational CHUNK-bit ripple adder built from per-bit full-adder cells.
  - Parameter: CHUNK.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and msb carry-in (used for overflow).
  - Exactly one instance lives in add_sub_serial.

## Test plan
Defaults WIDTH=16, CHUNK=4 unless noted.
- Add 0x1234 + 0x0FFF → o_sum=0x2233, o_cout=0, o_ovf=0; o_valid high 4 cycles after the acceptance edge.
- Subtract 0x0005 − 0x0007 → o_sum=0xFFFE, o_cout=0 (borrow), o_ovf=0. Subtract 0x8000 − 0x0001 → o_sum=0x7FFF, o_cout=1, o_ovf=1.
- Add 0x7FFF + 0x0001 → o_sum=0x8000, o_ovf=1, o_cout=0. Add 0xFFFF + 0x0001 → o_sum=0x0000, o_cout=1, o_ovf=0.
- Backpressure: hold i_ready=0 for 3 cycles in DONE while pulsing i_valid with new operands → o_valid stays 1, o_sum and o_cout are unchanged, o_ready stays 0, and the new request is not taken.
- Assert i_rst during CALC slice 2 → next cycle o_ready=1, o_valid=0, o_sum=0, o_cout=0. A subsequent request 0x0001 + 0x0001 returns 0x0002.
- WIDTH=8, CHUNK=8: add 0xF0 + 0x20 → o_sum=0x10, o_cout=1; o_valid one cycle after acceptance. Repeat with the macro undefined and confirm the build compiles without o_ovf.
